sout_frame_rx: RTL and testbench



---
 rtl/sout_rx_pkg.sv | 30 +++
 rtl/sout_rx_fifo.sv | 80 ++++++++
 rtl/sout_frame_rx.sv | 219 +++++++++++++++++++++
 tb/tb_sout_frame_rx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sout_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sout_rx_pkg
//  Description : Shared types and constants for the Sout serial frame
//                receiver: FSM state encoding, FIFO entry layout, word and
//                slot sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package sout_rx_pkg;

    localparam int SAMPLE_BITS     = 10;
    localparam int WORDS_PER_FRAME = 4;
    localparam int CHAN_W          = $clog2(WORDS_PER_FRAME);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic [SAMPLE_BITS-1:0] data;
        logic [CHAN_W-1:0]      chan;
        logic                   last;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage
`default_nettype wire

// File: rtl/sout_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sout_rx_fifo
//  Description : Synchronous FIFO with a registered head-of-queue output.
//                A write into a full FIFO succeeds only when a read happens
//                in the same cycle; otherwise it is dropped and flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module sout_rx_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             wr_accept,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic [AW-1:0]    w_rd_ptr_nxt;
    logic [WIDTH-1:0] w_head_nxt;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == (AW+1)'(DEPTH));
    assign w_pop        = rd_en & ~w_empty;
    assign wr_accept    = wr_en & (~w_full | w_pop);
    assign overflow     = wr_en & w_full & ~w_pop;
    assign w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
    // A write landing on the slot that becomes the head bypasses the array
    assign w_head_nxt   = (wr_accept && (r_wr_ptr == w_rd_ptr_nxt)) ? wr_data
                                                                    : r_mem[w_rd_ptr_nxt];

    assign rd_valid = ~w_empty;
    assign rd_data  = r_head;

    // Storage array write port
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and registered head entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (wr_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            unique case ({wr_accept, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            r_head <= w_head_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sout_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : sout_frame_rx
//  Description : Receiver for the ClkOut/DataOut serial pair. Synchronises
//                the inputs, hunts for the all-ones header, deserialises
//                MSB-first ADC words tagged with their slot index and queues
//                them on a valid/ready stream.
//                Optional: define SOUT_RX_STATS_EN to add frame_cnt/drop_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module sout_frame_rx
    import sout_rx_pkg::*;
#(
    parameter int HDR_BITS     = 10,
    parameter int IDLE_TIMEOUT = 64,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                   fpga_clock,
    input  logic                   rst,
    input  logic                   sclk_in,
    input  logic                   sdata_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SAMPLE_BITS-1:0] out_data,
    output logic [CHAN_W-1:0]      out_chan,
    output logic                   out_last,
`ifdef SOUT_RX_STATS_EN
    output logic [15:0]            frame_cnt,
    output logic [15:0]            drop_cnt,
`endif
    output logic                   err_timeout,
    output logic                   err_overflow
);

    localparam int HW = $clog2(HDR_BITS + 1);
    localparam int BW = $clog2(SAMPLE_BITS + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [HW-1:0]     HDR_LAST  = HW'(HDR_BITS - 1);
    localparam logic [BW-1:0]     BIT_LAST  = BW'(SAMPLE_BITS - 1);
    localparam logic [IW-1:0]     IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [CHAN_W-1:0] SLOT_LAST = CHAN_W'(WORDS_PER_FRAME - 1);

    rx_state_t              r_state;
    rx_state_t              w_state_nxt;

    logic                   r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic                   r_sdata_s1, r_sdata_s2;
    logic [HW-1:0]          r_hdr_cnt;
    logic [BW-1:0]          r_bit_cnt;
    logic [IW-1:0]          r_idle_cnt;
    logic [CHAN_W-1:0]      r_slot;
    logic [SAMPLE_BITS-2:0] r_shreg;

    logic                   w_edge;
    logic                   w_bit;
    logic                   w_hdr_done;
    logic                   w_word_done;
    logic                   w_last_slot;
    logic                   w_timeout;
    logic                   w_push;
    fifo_entry_t            w_entry;
    fifo_entry_t            w_head;
    logic                   w_push_ok;
    logic                   w_overflow;

    assign w_edge      = r_sclk_s2 & ~r_sclk_d;
    assign w_bit       = r_sdata_s2;
    assign w_last_slot = (r_slot == SLOT_LAST);
    assign w_hdr_done  = (r_state == HUNT) && w_edge && w_bit && (r_hdr_cnt == HDR_LAST);
    assign w_word_done = (r_state == DATA) && w_edge && (r_bit_cnt == BIT_LAST);
    assign w_timeout   = (r_state != HUNT) && !w_edge && (r_idle_cnt == IDLE_LAST);

    // Equal-depth synchronisers so data and clock stay aligned; extra sclk stage for edge detect
    always_ff @(posedge fpga_clock) begin
        if (rst) begin
            r_sclk_s1  <= 1'b0;
            r_sclk_s2  <= 1'b0;
            r_sclk_d   <= 1'b0;
            r_sdata_s1 <= 1'b0;
            r_sdata_s2 <= 1'b0;
        end else begin
            r_sclk_s1  <= sclk_in;
            r_sclk_s2  <= r_sclk_s1;
            r_sclk_d   <= r_sclk_s2;
            r_sdata_s1 <= sdata_in;
            r_sdata_s2 <= r_sdata_s1;
        end
    end

    // FSM state register
    always_ff @(posedge fpga_clock) begin
        if (rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state decode
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            HUNT: begin
                if (w_hdr_done) w_state_nxt = HDR;
            end
            HDR: begin
                if (w_timeout)            w_state_nxt = HUNT;
                else if (w_edge && !w_bit) w_state_nxt = DATA;
            end
            DATA: begin
                if (w_timeout)                       w_state_nxt = HUNT;
                else if (w_word_done && w_last_slot) w_state_nxt = HUNT;
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    // FSM outputs: push the completed word with its slot tag
    always_comb begin
        w_push        = w_word_done;
        w_entry.data  = {r_shreg, w_bit};
        w_entry.chan  = r_slot;
        w_entry.last  = w_last_slot;
    end

    // Header counter, idle timer, shifter, bit/slot counters and sticky errors
    always_ff @(posedge fpga_clock) begin
        if (rst) begin
            r_hdr_cnt    <= '0;
            r_idle_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_slot       <= '0;
            r_shreg      <= '0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (r_state != HUNT) begin
                r_hdr_cnt <= '0;
            end else if (w_edge) begin
                r_hdr_cnt <= (w_bit && !w_hdr_done) ? r_hdr_cnt + HW'(1) : '0;
            end

            if ((r_state == HUNT) || w_edge) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + IW'(1);
            end

            unique case (r_state)
                HDR: begin
                    r_slot <= '0;
                    if (w_edge && !w_bit) begin
                        r_shreg   <= {r_shreg[SAMPLE_BITS-3:0], w_bit};
                        r_bit_cnt <= BW'(1);
                    end
                end
                DATA: begin
                    if (w_timeout) begin
                        r_bit_cnt <= '0;
                        r_slot    <= '0;
                    end else if (w_edge) begin
                        r_shreg <= {r_shreg[SAMPLE_BITS-3:0], w_bit};
                        if (w_word_done) begin
                            r_bit_cnt <= '0;
                            r_slot    <= w_last_slot ? '0 : r_slot + CHAN_W'(1);
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end
                end
                default: begin
                    r_bit_cnt <= '0;
                    r_slot    <= '0;
                end
            endcase

            if (w_timeout)  err_timeout  <= 1'b1;
            if (w_overflow) err_overflow <= 1'b1;
        end
    end

    sout_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (fpga_clock),
        .rst       (rst),
        .wr_en     (w_push),
        .wr_data   (w_entry),
        .rd_en     (out_ready),
        .rd_valid  (out_valid),
        .rd_data   (w_head),
        .wr_accept (w_push_ok),
        .overflow  (w_overflow)
    );

    assign out_data = w_head.data;
    assign out_chan = w_head.chan;
    assign out_last = w_head.last;

`ifdef SOUT_RX_STATS_EN
    // Wrapping frame and drop counters
    always_ff @(posedge fpga_clock) begin
        if (rst) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (w_push_ok && w_entry.last) frame_cnt <= frame_cnt + 16'd1;
            if (w_overflow || w_timeout)   drop_cnt  <= drop_cnt + 16'd1;
        end
    end
`else
    logic w_unused_stats;
    assign w_unused_stats = w_push_ok;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sout_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sout_frame_rx
//  Description : Directed self-checking bench for sout_frame_rx: framing,
//                false header, idle timeout, overflow, full+pop, mid-word
//                reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sout_frame_rx;
    import sout_rx_pkg::*;

    logic                   fpga_clock = 1'b0;
    logic                   rst        = 1'b1;
    logic                   sclk_in    = 1'b0;
    logic                   sdata_in   = 1'b0;
    logic                   out_ready  = 1'b0;
    logic                   out_valid;
    logic [SAMPLE_BITS-1:0] out_data;
    logic [CHAN_W-1:0]      out_chan;
    logic                   out_last;
    logic                   err_timeout;
    logic                   err_overflow;
`ifdef SOUT_RX_STATS_EN
    logic [15:0]            frame_cnt;
    logic [15:0]            drop_cnt;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [12:0] rx_q  [$];
    logic [12:0] exp_q [$];

    sout_frame_rx dut (
        .fpga_clock   (fpga_clock),
        .rst          (rst),
        .sclk_in      (sclk_in),
        .sdata_in     (sdata_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_chan     (out_chan),
        .out_last     (out_last),
`ifdef SOUT_RX_STATS_EN
        .frame_cnt    (frame_cnt),
        .drop_cnt     (drop_cnt),
`endif
        .err_timeout  (err_timeout),
        .err_overflow (err_overflow)
    );

    always #5 fpga_clock = ~fpga_clock;

    // Record every handshake; values are stable mid-cycle
    always @(negedge fpga_clock) begin
        if (!rst && out_valid && out_ready) begin
            rx_q.push_back({out_data, out_chan, out_last});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge fpga_clock);
        #2;
    endtask

    // One serial bit: data set with sclk low, sclk low 2 cycles then high.
    // pop_on_edge raises out_ready for exactly the cycle the word is pushed
    // (edge seen 3 cycles after sclk rises).
    task automatic send_bit(input logic b, input bit pop_on_edge);
        sdata_in = b;
        tick();
        tick();
        sclk_in = 1'b1;
        if (pop_on_edge) begin
            tick();
            tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end else begin
            tick();
            tick();
        end
        sclk_in = 1'b0;
    endtask

    task automatic send_word(input logic [9:0] w, input bit pop_last);
        for (int i = 9; i >= 0; i--) begin
            send_bit(w[i], pop_last && (i == 0));
        end
    endtask

    task automatic send_hdr(input int n);
        repeat (n) send_bit(1'b1, 1'b0);
    endtask

    task automatic expect_word(input logic [9:0] w, input int slot);
        exp_q.push_back({w, 2'(slot), (slot == 3)});
    endtask

    task automatic send_frame(input logic [39:0] ws, input bit record);
        logic [9:0] w;
        send_hdr(10);
        for (int i = 0; i < 4; i++) begin
            w = ws[39 - 10*i -: 10];
            send_word(w, 1'b0);
            if (record) expect_word(w, i);
        end
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("%s_word%0d", tag, i), rx_q[i], exp_q[i]);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [9:0] w;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge fpga_clock);
        check("rst_valid", out_valid, 0);
        check("rst_data", {out_data, out_chan, out_last}, 0);
        check("rst_errs", {err_timeout, err_overflow}, 0);
        tick();

        // A: basic frame, including all-ones and MSB-set words
        out_ready = 1'b1;
        send_frame({10'h155, 10'h2AA, 10'h3FF, 10'h001}, 1'b1);
        repeat (10) tick();
        compare("basic");
        check("basic_errs", {err_timeout, err_overflow}, 0);

        // B: 9-one header is rejected, then a real frame decodes
        send_hdr(9);
        send_bit(1'b0, 1'b0);
        send_word(10'h155, 1'b0);
        send_word(10'h2AA, 1'b0);
        repeat (10) tick();
        compare("short_hdr");
        send_frame({10'h0AB, 10'h3C3, 10'h100, 10'h2F0}, 1'b1);
        repeat (10) tick();
        compare("after_short");

        // C: sclk stalls inside word 2
        send_hdr(10);
        send_word(10'h123, 1'b0);
        expect_word(10'h123, 0);
        send_word(10'h321, 1'b0);
        expect_word(10'h321, 1);
        w = 10'h2C5;
        for (int i = 9; i >= 5; i--) send_bit(w[i], 1'b0);
        repeat (80) tick();
        check("to_flag", err_timeout, 1);
        check("to_ovf", err_overflow, 0);
        compare("timeout");
`ifdef SOUT_RX_STATS_EN
        check("to_drop_cnt", drop_cnt, 1);
`endif
        send_frame({10'h055, 10'h0AA, 10'h1FE, 10'h201}, 1'b1);
        repeat (10) tick();
        compare("after_to");

        // D: stalled consumer across 3 frames
        pulse_reset();
        check("clr_to", err_timeout, 0);
        out_ready = 1'b0;
        send_frame({10'h011, 10'h122, 10'h233, 10'h344}, 1'b1);
        send_frame({10'h055, 10'h166, 10'h277, 10'h388}, 1'b1);
        send_frame({10'h099, 10'h1AA, 10'h2BB, 10'h3CC}, 1'b0);
        repeat (5) tick();
        check("ovf_flag", err_overflow, 1);
        check("ovf_valid", out_valid, 1);
`ifdef SOUT_RX_STATS_EN
        check("ovf_drop_cnt", drop_cnt, 4);
        check("ovf_frame_cnt", frame_cnt, 2);
`endif
        out_ready = 1'b1;
        repeat (20) tick();
        compare("overflow");

        // E: full FIFO popped in the very cycle a word completes
        pulse_reset();
        out_ready = 1'b0;
        send_frame({10'h101, 10'h202, 10'h303, 10'h004}, 1'b1);
        send_frame({10'h015, 10'h126, 10'h237, 10'h348}, 1'b1);
        send_hdr(10);
        send_word(10'h0E9, 1'b1);
        expect_word(10'h0E9, 0);
        repeat (3) tick();
        check("fullpop_ovf", err_overflow, 0);
        out_ready = 1'b1;
        send_word(10'h3EA, 1'b0);
        expect_word(10'h3EA, 1);
        send_word(10'h1EB, 1'b0);
        expect_word(10'h1EB, 2);
        send_word(10'h2EC, 1'b0);
        expect_word(10'h2EC, 3);
        repeat (20) tick();
        compare("fullpop");
        check("fullpop_ovf_end", err_overflow, 0);

        // F: set a sticky error, then reset in the middle of word 1
        send_hdr(10);
        repeat (80) tick();
        check("pre_rst_to", err_timeout, 1);
        out_ready = 1'b0;
        send_hdr(10);
        send_word(10'h0F0, 1'b0);
        w = 10'h1E1;
        for (int i = 9; i >= 5; i--) send_bit(w[i], 1'b0);
        repeat (3) tick();
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge fpga_clock);
        check("midrst_valid", out_valid, 0);
        check("midrst_errs", {err_timeout, err_overflow}, 0);
        tick();
        out_ready = 1'b1;
        send_frame({10'h0CC, 10'h2DD, 10'h3EE, 10'h1FF}, 1'b1);
        repeat (10) tick();
        compare("after_rst");
        check("final_errs", {err_timeout, err_overflow}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        err_cnt++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
